// File: rtl/multi_divisor_clock_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master drives enables, divisor values and load strobes; the slave returns waveforms.
interface multi_divisor_clock_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 16
);
    logic [N_CH-1:0]       en;
    logic [N_CH*CNT_W-1:0] div_val;
    logic [N_CH-1:0]       load;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       busy;

    modport master (
        output en, div_val, load,
        input  clk_out, tick, busy
    );

    modport slave (
        input  en, div_val, load,
        output clk_out, tick, busy
    );
endinterface

// File: rtl/multi_divisor_clock.sv
// N_CH independent square-wave dividers with a half-period of A+1 clk cycles each.
// Divisor changes made while running are held pending and applied at the next toggle.
module multi_divisor_clock #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4999
) (
    input logic                  clk,
    input logic                  rst,
    multi_divisor_clock_if.slave bus
);

    localparam logic [CNT_W-1:0] ResetDiv = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] act_q [N_CH];
    logic [CNT_W-1:0] pnd_q [N_CH];
    logic [CNT_W-1:0] div_w [N_CH];
    logic [N_CH-1:0]  pend_q;
    logic [N_CH-1:0]  out_q;
    logic [N_CH-1:0]  tick_q;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            div_w[i] = bus.div_val[i*CNT_W +: CNT_W];
        end
    end

    // Each channel is IDLE or RUN according to en as sampled at the edge, so the
    // edge that enables a channel is already its first counting edge.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rst) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= ResetDiv;
                pnd_q[i]  <= '0;
                pend_q[i] <= 1'b0;
                out_q[i]  <= 1'b0;
                tick_q[i] <= 1'b0;
            end else begin
                tick_q[i] <= 1'b0;
                if (!bus.en[i]) begin
                    cnt_q[i] <= '0;
                    out_q[i] <= 1'b0;
                    if (bus.load[i]) begin
                        act_q[i]  <= div_w[i];
                        pend_q[i] <= 1'b0;
                    end
                end else if (cnt_q[i] >= act_q[i]) begin
                    cnt_q[i]  <= '0;
                    out_q[i]  <= ~out_q[i];
                    tick_q[i] <= 1'b1;
                    pend_q[i] <= 1'b0;
                    // A load landing on the wrap edge wins over an older pending value.
                    if (bus.load[i]) begin
                        act_q[i] <= div_w[i];
                    end else if (pend_q[i]) begin
                        act_q[i] <= pnd_q[i];
                    end
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    if (bus.load[i]) begin
                        pnd_q[i]  <= div_w[i];
                        pend_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.clk_out = out_q;
    assign bus.tick    = tick_q;
    assign bus.busy    = pend_q;

endmodule

// File: doc/multi_divisor_clock.md
MULTI_DIVISOR_CLOCK -- requirements
Module: multi_divisor_clock

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent divider channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16: width of each channel's half-period count.
REQ-003 SHALL have parameter DEFAULT_DIV, default 4999: active half-period count loaded at reset. At a 100 MHz clk this gives a 10 kHz output.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  N_CH  per-channel run enable.
REQ-007 SHALL have port div_val  input  N_CH*CNT_W  per-channel requested half-period count D; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 SHALL have port load  input  N_CH  per-channel one-cycle strobe that captures div_val for that channel.
REQ-009 SHALL have port clk_out  output  N_CH  per-channel divided square wave, registered.
REQ-010 SHALL have port tick  output  N_CH  per-channel one-cycle pulse, asserted in the cycle after each clk_out toggle edge.
REQ-011 SHALL have port busy  output  N_CH  per-channel flag: a loaded value is pending and not yet applied.

Function
REQ-012 Each channel SHALL hold a CNT_W-bit counter, an active divisor A, a pending divisor P and a pending flag.
REQ-013 Each channel SHALL have two states, IDLE and RUN. en=1 moves IDLE->RUN. en=0 moves RUN->IDLE. Transitions take effect at the sampling edge.
REQ-014 In IDLE, the counter SHALL be 0, clk_out SHALL be 0 and tick SHALL be 0. When en falls, the channel SHALL enter IDLE at the next edge, forcing clk_out to 0 mid-period.
REQ-015 In RUN, at each edge with counter /= A, the counter SHALL increment by 1.
REQ-016 In RUN, at each edge with counter == A, the channel SHALL in the same edge:
- set the counter to 0;
- toggle clk_out;
- drive tick to 1 for exactly one cycle.
REQ-017 The half-period SHALL be A+1 clk cycles and the full period 2*(A+1) cycles. A=0 SHALL give a toggle on every enabled edge (period 2).
REQ-018 The first toggle after an IDLE->RUN transition SHALL occur on the (A+1)-th edge with en=1, starting from counter 0.
REQ-019 A load in IDLE SHALL write div_val directly to A, leave the pending flag at 0 and keep busy=0.
REQ-020 A load in RUN SHALL write div_val to P and set the pending flag (busy=1 from the next cycle).
REQ-021 At the next wrap (REQ-016), the channel SHALL copy P to A and clear the pending flag. A change therefore never truncates or extends the half-period in progress.
REQ-022 When load and wrap coincide in RUN, the new div_val SHALL become A at that edge and the pending flag SHALL stay 0.
REQ-023 When a second load arrives while a value is pending, it SHALL overwrite P; only the last value SHALL be applied.
REQ-024 When load and en-fall coincide, the channel SHALL treat the load as an IDLE load: A is updated and the pending flag is cleared.
REQ-025 Channels SHALL be fully independent: no shared counter, and no cross-channel effect of en or load.
REQ-026 Arithmetic SHALL be unsigned CNT_W-bit. The counter SHALL never exceed A; no wrap-around past 2^CNT_W-1 SHALL occur.

Reset
REQ-027 While rst=1 at an edge, every channel SHALL reset as follows:
- counter=0, clk_out=0, tick=0, busy=0;
- pending flag cleared, P=0;
- A=DEFAULT_DIV truncated to CNT_W bits;
- state IDLE.
REQ-028 rst SHALL take priority over en and load in the same cycle. A reset mid-period SHALL abort the period with no tick.

Verification
REQ-029 Reset, then en[0]=1 with the default A=4999 -> first clk_out[0] toggle at the 5000th edge; period 10000 cycles; tick[0] is one cycle wide at each toggle.
REQ-030 In IDLE, load D=0, then set en=1 -> clk_out toggles every cycle (period 2); tick is high every cycle.
REQ-031 RUN with A=9, load D=3 at counter=2 -> current half-period stays 10 cycles; following half-periods are 4 cycles; busy is 1 from the load until the wrap.
REQ-032 Load D=7 in the same cycle as a wrap with A=5 -> the next half-period is 8 cycles and busy stays 0. Two loads (D=2, then D=6) before a wrap -> only 6 is applied.
REQ-033 Drop en at counter=3 while clk_out=1 -> clk_out=0 and counter=0 the next cycle, with no tick. Re-enable -> first toggle after A+1 edges.
REQ-034 With N_CH=2 at A=1 and A=2, assert rst mid-run -> all outputs are 0 next cycle and A returns to DEFAULT_DIV. Channel 1 timing is unaffected by load/en activity on channel 0.
